// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: table-driven pattern generator.
//
// A DEPTH-entry table of {flag, data} words is written while the block is
// idle. A start request plays entries 0..len in order on a valid/ready output.
// Entries with flag=1 are data beats held until accepted. Entries with
// flag=0 are gap slots that last one cycle. Repeat mode wraps back to entry 0.
//
// Configuration macro: SEQ_GEN_GAP_EN
//   defined   - per-entry flag storage; gap slots are honoured.
//   undefined - no flag storage; i_wr_vld is ignored; every entry is a beat.
//
// Ports:
//   sclk, rst        clock, synchronous active-high reset
//   i_wr_en/addr/    table write port; ignored while o_busy=1
//   data/vld
//   i_start, i_stop  start (idle only) / abort (run only) requests
//   i_loop, i_len    repeat mode and last entry index, latched at start
//   i_ready          downstream accept
//   o_dv, o_data     output beat; o_data is 0 whenever o_dv=0
//   o_busy           high while a sequence is running
//   o_done           one-cycle pulse after the last entry of a non-looping run

module seq_pattern_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_wr_vld,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop,
    input  logic [AW-1:0]     i_len,
    input  logic              i_ready,
    output logic              o_dv,
    output logic [DATA_W-1:0] o_data,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     len_q, len_d;
    logic              loop_q, loop_d;
    logic              run;
    logic              cur_flag;
    logic              consume;
    logic              tbl_we;

    logic [DATA_W-1:0] data_q [DEPTH];

    assign run    = (state_q == StRun);
    assign tbl_we = i_wr_en && !run;

    // Table data storage; reset clears every word.
    always_ff @(posedge sclk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else if (tbl_we) begin
            data_q[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef SEQ_GEN_GAP_EN
    logic [DEPTH-1:0] flag_q;

    // Flags reset to 1 so an unwritten table plays as plain data beats.
    always_ff @(posedge sclk) begin
        if (rst) begin
            flag_q <= '1;
        end else if (tbl_we) begin
            flag_q[i_wr_addr] <= i_wr_vld;
        end
    end

    assign cur_flag = flag_q[ptr_q];
`else
    logic unused_wr_vld;

    assign unused_wr_vld = i_wr_vld;
    assign cur_flag      = 1'b1;
`endif

    // A data beat needs a handshake; a gap slot retires after one cycle.
    assign consume = run && (cur_flag ? i_ready : 1'b1);

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        loop_d  = loop_q;
        case (state_q)
            StIdle: begin
                if (i_start && !i_stop) begin
                    state_d = StRun;
                    ptr_d   = '0;
                    len_d   = i_len;
                    loop_d  = i_loop;
                end
            end
            StRun: begin
                // Stop wins over a same-cycle consume; a pending beat is dropped.
                if (i_stop) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else if (consume) begin
                    if (ptr_q == len_q) begin
                        ptr_d = '0;
                        if (!loop_q) begin
                            state_d = StDone;
                        end
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_dv   = run && cur_flag;
        o_data = '0;
        if (o_dv) begin
            o_data = data_q[ptr_q];
        end
        o_busy = run;
        o_done = (state_q == StDone);
    end

endmodule
